rca_operand_loader: RTL

Upstream stage of the 32-bit ripple-carry adder. It assembles two full-width operands, A and B, plus a carry-in from a byte-serial valid/ready stream fed by the 8-bit pads. It then holds the completed pair stable on a valid/ready output until the adder side consumes it. This removes the zero-extension limitation, so all 32 operand bits can reach the adder.

---
 rtl/rca_pkg.sv | 13 +
 rtl/rca_byte_shifter.sv | 29 ++
 rtl/rca_operand_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the ripple-carry adder operand path.
package rca_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        FULL
    } state_e;

endpackage

// File: rtl/rca_byte_shifter.sv
// Byte-lane write register: one lane written per enabled cycle.
module rca_byte_shifter
    import rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NBYTES = WIDTH / BYTE_W,
    parameter int IDX_W  = $clog2(NBYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] din,
    output logic [WIDTH-1:0]  q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (idx == IDX_W'(i)) begin
                    q[i*BYTE_W +: BYTE_W] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/rca_operand_loader.sv
// Assembles A, B and carry-in from a byte stream and holds them for the adder.
module rca_operand_loader
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_cin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  a_out,
    output logic [WIDTH-1:0]  b_out,
    output logic              cin_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last;
    logic               we_a;
    logic               we_b;

    assign in_ready = (state != FULL);
    assign busy     = (state != LOAD_A) || (cnt != '0);
    assign last     = (cnt == CNT_W'(NBYTES - 1));

    // clear wins over a concurrent byte: the lanes must not see it either
    assign accept = in_valid && in_ready && !clear;
    assign we_a   = accept && (state == LOAD_A);
    assign we_b   = accept && (state == LOAD_B);

    rca_byte_shifter #(
        .WIDTH  (WIDTH),
        .NBYTES (NBYTES),
        .IDX_W  (CNT_W)
    ) u_shift_a (
        .clk (clk),
        .rst (rst),
        .we  (we_a),
        .idx (cnt),
        .din (in_byte),
        .q   (a_out)
    );

    rca_byte_shifter #(
        .WIDTH  (WIDTH),
        .NBYTES (NBYTES),
        .IDX_W  (CNT_W)
    ) u_shift_b (
        .clk (clk),
        .rst (rst),
        .we  (we_b),
        .idx (cnt),
        .din (in_byte),
        .q   (b_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            cnt       <= '0;
            cin_out   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= LOAD_A;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (last) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (last) begin
                            cnt       <= '0;
                            cin_out   <= in_cin;
                            out_valid <= 1'b1;
                            state     <= FULL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= LOAD_A;
                end
            endcase
        end
    end

endmodule
